// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: issues word fetches to a synchronous imem, buffers the returned
// instructions with their PCs in a small FIFO and hands them to ID under valid/ready.
module fetch_queue_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter logic [XLEN-1:0] NOP  = 32'h0000_0013
) (
  input  logic                     clock,
  input  logic                     clear,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_rd_en,
  input  logic [XLEN-1:0]          imem_data,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          id_instr,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q;
  logic              resp_pending_q;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [XLEN-1:0]   instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

  logic space;
  logic push;
  logic pop;
  logic fifo_empty;

  // Occupancy plus the outstanding response must leave room; a same-cycle pop is not credited.
  assign space      = (count_q + CntW'(resp_pending_q)) < CntW'(DEPTH);
  assign imem_rd_en = clear & (redirect | space);
  assign imem_addr  = redirect ? redirect_pc : pc_q;

  assign fifo_empty = (count_q == '0);
  assign push       = resp_pending_q & ~redirect;
  assign id_valid   = ~fifo_empty & ~redirect;
  assign pop        = id_valid & id_ready;

  assign id_instr = fifo_empty ? NOP : instr_mem_q[rd_ptr_q];
  assign id_pc    = fifo_empty ? '0 : pc_mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (imem_rd_en) begin
      pc_d = imem_addr + ADDR_W'(1);
    end
    if (redirect) begin
      // Squash everything queued; only the fetch issued this cycle survives.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_q           <= ADDR_W'(RESET_PC);
      tag_q          <= '0;
      resp_pending_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      pc_q           <= pc_d;
      tag_q          <= imem_addr;
      resp_pending_q <= imem_rd_en;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // Storage is not reset; empty-FIFO reads are masked to NOP/0 above.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q]    <= tag_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: synchronous imem model with imem[k] = k + 0x100 and
// a scoreboard of expected delivered PCs, compared on every ID handshake.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        clear;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data = '0;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic [2:0]  count;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sb_q [$];
  logic [7:0]  exp_pc;

  fetch_queue_unit #(
    .XLEN    (32),
    .ADDR_W  (8),
    .DEPTH   (DEPTH),
    .RESET_PC(0),
    .NOP     (NOP)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .count      (count)
  );

  always #5 clock = ~clock;

  // Synchronous instruction RAM
  always @(posedge clock) begin
    if (imem_rd_en) imem_data <= 32'h100 + {24'h0, imem_addr};
  end

  // Occupancy plus outstanding response must never exceed DEPTH
  always @(negedge clock) begin
    if (clear === 1'b1) begin
      checks++;
      if (32'(count) + 32'(dut.resp_pending_q) > DEPTH) begin
        errors++;
        $display("FAIL invariant: count=%0d resp=%0d exceeds %0d", count, dut.resp_pending_q,
                 DEPTH);
      end
    end
  end

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0, the first cycle with clear released
  task automatic do_reset;
    clear       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b1;
  endtask

  task automatic test_reset;
    clear = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 8'h00 || imem_rd_en !== 1'b0 ||
        count !== 3'd0) begin
      errors++;
      $display("FAIL reset: valid=%b instr=%h pc=%h rd_en=%b count=%0d, want 0/%h/00/0/0",
               id_valid, id_instr, id_pc, imem_rd_en, count, NOP);
    end
  endtask

  task automatic test_stream;
    do_reset();
    id_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) next_cycle();
      sb_q.push_back(8'(k));
      @(negedge clock);
      checks++;
      if (imem_rd_en !== 1'b1 || imem_addr !== 8'(k)) begin
        errors++;
        $display("FAIL stream_issue c%0d: rd_en=%b addr=%h, want 1/%h", k, imem_rd_en, imem_addr,
                 8'(k));
      end
      checks++;
      if (id_valid !== 1'(k >= 2)) begin
        errors++;
        $display("FAIL stream_valid c%0d: id_valid=%b want %b", k, id_valid, k >= 2);
      end
      if (k < 2) begin
        checks++;
        if (id_instr !== NOP || id_pc !== 8'h00) begin
          errors++;
          $display("FAIL stream_empty c%0d: instr=%h pc=%h want %h/00", k, id_instr, id_pc, NOP);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: pc=%h delivered with empty scoreboard", id_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (id_pc !== exp_pc || id_instr !== 32'h100 + {24'h0, exp_pc}) begin
            errors++;
            $display("FAIL stream_deliver: got %h/%h want %h/%h", id_pc, id_instr, exp_pc,
                     32'h100 + {24'h0, exp_pc});
          end
        end
      end
    end
  endtask

  task automatic test_stall;
    logic exp_en;
    do_reset();
    for (int i = 0; i < 20; i++) sb_q.push_back(8'(i));
    for (int k = 0; k < 16; k++) begin
      if (k > 0) next_cycle();
      id_ready = (k >= 8);
      @(negedge clock);
      exp_en = (k < 4) || (k >= 9);
      checks++;
      if (imem_rd_en !== exp_en) begin
        errors++;
        $display("FAIL stall_rd_en c%0d: rd_en=%b want %b", k, imem_rd_en, exp_en);
      end
      if (k < 4 || k == 9) begin
        checks++;
        if (imem_addr !== ((k == 9) ? 8'd4 : 8'(k))) begin
          errors++;
          $display("FAIL stall_addr c%0d: addr=%h", k, imem_addr);
        end
      end
      if (k == 7) begin
        checks++;
        if (count !== 3'd4) begin
          errors++;
          $display("FAIL stall_count: count=%0d want 4", count);
        end
      end
      if (k >= 8) begin
        checks++;
        if (id_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_gap c%0d: id_valid=%b want 1", k, id_valid);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL stall_extra: pc=%h delivered with empty scoreboard", id_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (id_pc !== exp_pc || id_instr !== 32'h100 + {24'h0, exp_pc}) begin
            errors++;
            $display("FAIL stall_deliver: got %h/%h want %h/%h", id_pc, id_instr, exp_pc,
                     32'h100 + {24'h0, exp_pc});
          end
        end
      end
    end
  endtask

  task automatic test_redirect;
    do_reset();
    for (int i = 0; i < 5; i++) sb_q.push_back(8'(i));
    for (int k = 0; k < 16; k++) begin
      if (k > 0) next_cycle();
      id_ready    = (k <= 6) || (k >= 10);
      redirect    = (k == 9);
      redirect_pc = 8'h40;
      if (k == 9) for (int i = 0; i < 6; i++) sb_q.push_back(8'h40 + 8'(i));
      @(negedge clock);
      if (k == 9) begin
        checks++;
        if (id_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 8'h40) begin
          errors++;
          $display("FAIL redir_cycle: valid=%b rd_en=%b addr=%h want 0/1/40", id_valid,
                   imem_rd_en, imem_addr);
        end
      end
      if (k == 10) begin
        checks++;
        if (count !== 3'd0 || id_valid !== 1'b0) begin
          errors++;
          $display("FAIL redir_flush: count=%0d valid=%b want 0/0", count, id_valid);
        end
      end
      if (k == 11) begin
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 8'h40) begin
          errors++;
          $display("FAIL redir_target: valid=%b pc=%h want 1/40", id_valid, id_pc);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL redir_extra: pc=%h delivered with empty scoreboard", id_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (id_pc !== exp_pc || id_instr !== 32'h100 + {24'h0, exp_pc}) begin
            errors++;
            $display("FAIL redir_deliver: got %h/%h want %h/%h", id_pc, id_instr, exp_pc,
                     32'h100 + {24'h0, exp_pc});
          end
        end
      end
    end
    redirect = 1'b0;
    checks++;
    if (sb_q.size() != 1) begin
      errors++;
      $display("FAIL redir_left: %0d entries undelivered want 1", sb_q.size());
    end
  endtask

  task automatic test_back_to_back_redirect;
    do_reset();
    for (int i = 0; i < 3; i++) sb_q.push_back(8'(i));
    for (int k = 0; k < 13; k++) begin
      if (k > 0) next_cycle();
      id_ready    = 1'b1;
      redirect    = (k == 5) || (k == 6);
      redirect_pc = (k == 5) ? 8'h10 : 8'h20;
      if (k == 6) for (int i = 0; i < 6; i++) sb_q.push_back(8'h20 + 8'(i));
      @(negedge clock);
      if (k >= 5 && k <= 7) begin
        checks++;
        if (id_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_bubble c%0d: id_valid=%b want 0", k, id_valid);
        end
      end
      if (k == 8) begin
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 8'h20) begin
          errors++;
          $display("FAIL b2b_first: valid=%b pc=%h want 1/20", id_valid, id_pc);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: pc=%h delivered with empty scoreboard", id_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (id_pc !== exp_pc || id_instr !== 32'h100 + {24'h0, exp_pc}) begin
            errors++;
            $display("FAIL b2b_deliver: got %h/%h want %h/%h", id_pc, id_instr, exp_pc,
                     32'h100 + {24'h0, exp_pc});
          end
        end
      end
    end
    redirect = 1'b0;
    checks++;
    if (sb_q.size() != 1) begin
      errors++;
      $display("FAIL b2b_left: %0d entries undelivered want 1", sb_q.size());
    end
  endtask

  task automatic test_wrap;
    do_reset();
    sb_q.push_back(8'h00);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) next_cycle();
      id_ready    = 1'b1;
      redirect    = (k == 3);
      redirect_pc = 8'hFE;
      if (k == 3) begin
        sb_q.push_back(8'hFE); sb_q.push_back(8'hFF); sb_q.push_back(8'h00);
        sb_q.push_back(8'h01); sb_q.push_back(8'h02);
      end
      @(negedge clock);
      if (k == 4 || k == 5) begin
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== ((k == 4) ? 8'hFF : 8'h00)) begin
          errors++;
          $display("FAIL wrap_issue c%0d: rd_en=%b addr=%h", k, imem_rd_en, imem_addr);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra: pc=%h delivered with empty scoreboard", id_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (id_pc !== exp_pc || id_instr !== 32'h100 + {24'h0, exp_pc}) begin
            errors++;
            $display("FAIL wrap_deliver: got %h/%h want %h/%h", id_pc, id_instr, exp_pc,
                     32'h100 + {24'h0, exp_pc});
          end
        end
      end
    end
    redirect = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_left: %0d entries undelivered want 0", sb_q.size());
    end
  endtask

  task automatic test_clear_mid;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next_cycle();
      @(negedge clock);
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL clear_pre: count=%0d want 3", count);
    end
    #1 clear = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 8'h00 || count !== 3'd0 ||
        imem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL clear_now: valid=%b instr=%h pc=%h count=%0d rd_en=%b", id_valid, id_instr,
               id_pc, count, imem_rd_en);
    end
    next_cycle();
    clear    = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) sb_q.push_back(8'(i));
    for (int k = 0; k < 7; k++) begin
      if (k > 0) next_cycle();
      @(negedge clock);
      if (k == 0) begin
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00) begin
          errors++;
          $display("FAIL clear_restart: rd_en=%b addr=%h want 1/00", imem_rd_en, imem_addr);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL clear_extra: pc=%h delivered with empty scoreboard", id_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (id_pc !== exp_pc || id_instr !== 32'h100 + {24'h0, exp_pc}) begin
            errors++;
            $display("FAIL clear_deliver: got %h/%h want %h/%h", id_pc, id_instr, exp_pc,
                     32'h100 + {24'h0, exp_pc});
          end
        end
      end
    end
    checks++;
    if (sb_q.size() != 1) begin
      errors++;
      $display("FAIL clear_left: %0d entries undelivered want 1", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_wrap();
    test_clear_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
